reg_file_sb: RTL and testbench

//   Integer register file at the far end of the writeback interface: takes
//   the write (wdata/dest_reg/we) produced by the WB stage and serves two

---
 rtl/riscv_cpu_pkg.sv | 13 +
 rtl/reg_scoreboard.sv | 72 +++++++
 rtl/reg_file_sb.sv | 70 +++++++
 tb/tb_reg_file_sb.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/riscv_cpu_pkg.sv
// rtl/riscv_cpu_pkg.sv - shared register-file widths and types for the integer pipeline
package riscv_cpu_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 5;
  localparam int NUM_REGS   = 2 ** ADDR_WIDTH;
  localparam int CNT_WIDTH  = 2;

  typedef logic [ADDR_WIDTH-1:0] reg_addr_t;
  typedef logic [DATA_WIDTH-1:0] reg_data_t;
  typedef logic [CNT_WIDTH-1:0]  sb_cnt_t;

endpackage

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - per-register in-flight write counters with busy and full flags
module reg_scoreboard #(
  parameter int ADDR_WIDTH = riscv_cpu_pkg::ADDR_WIDTH,
  parameter int CNT_WIDTH  = riscv_cpu_pkg::CNT_WIDTH,
  parameter int BYPASS     = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  issue_i,
  input  logic [ADDR_WIDTH-1:0] issue_dest_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] dest_reg_i,
  input  logic [ADDR_WIDTH-1:0] raddr_a_i,
  input  logic [ADDR_WIDTH-1:0] raddr_b_i,
  output logic                  busy_a_o,
  output logic                  busy_b_o,
  output logic                  sb_full_o
);

  localparam int                   NUM_REGS = 2 ** ADDR_WIDTH;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam bit                   BYP_EN   = (BYPASS != 0);

  logic [CNT_WIDTH-1:0] cnt_q [NUM_REGS];

  function automatic logic hit(input logic v, input logic [ADDR_WIDTH-1:0] a, input int r);
    return v && (a == ADDR_WIDTH'(r));
  endfunction

  // cnt_q[0] is never updated after reset, so x0 can never look busy or full
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt_q[r] <= '0;
      end
    end else begin
      for (int r = 1; r < NUM_REGS; r++) begin
        if (hit(issue_i, issue_dest_i, r) && !hit(we_i, dest_reg_i, r)) begin
          if (cnt_q[r] != CNT_MAX) begin
            cnt_q[r] <= cnt_q[r] + CNT_ONE;
          end
        end else if (hit(we_i, dest_reg_i, r) && !hit(issue_i, issue_dest_i, r)) begin
          if (cnt_q[r] != '0) begin
            cnt_q[r] <= cnt_q[r] - CNT_ONE;
          end
        end
      end
    end
  end

  logic [CNT_WIDTH-1:0] cnt_a, cnt_b;
  logic                 retire_a, retire_b;

  assign cnt_a    = cnt_q[raddr_a_i];
  assign cnt_b    = cnt_q[raddr_b_i];
  assign retire_a = BYP_EN && we_i && (dest_reg_i == raddr_a_i) && (cnt_a == CNT_ONE);
  assign retire_b = BYP_EN && we_i && (dest_reg_i == raddr_b_i) && (cnt_b == CNT_ONE);

  // Counts are pre-issue, so an instruction never stalls on its own destination
  assign busy_a_o  = (cnt_a != '0) && !retire_a;
  assign busy_b_o  = (cnt_b != '0) && !retire_b;
  assign sb_full_o = (cnt_q[issue_dest_i] == CNT_MAX);

  // An issue on a full register is only tolerated when a retire to it lands in the same cycle
  issue_when_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(issue_i && sb_full_o && !(we_i && dest_reg_i == issue_dest_i)));

  retire_without_issue: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(we_i && dest_reg_i != '0 && cnt_q[dest_reg_i] == '0));

endmodule

// File: rtl/reg_file_sb.sv
// rtl/reg_file_sb.sv - integer register file with WB bypass and RAW hazard scoreboard
module reg_file_sb #(
  parameter int DATA_WIDTH = riscv_cpu_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = riscv_cpu_pkg::ADDR_WIDTH,
  parameter int BYPASS     = 1,
  parameter int CNT_WIDTH  = riscv_cpu_pkg::CNT_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] dest_reg_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [ADDR_WIDTH-1:0] raddr_a_i,
  input  logic [ADDR_WIDTH-1:0] raddr_b_i,
  output logic [DATA_WIDTH-1:0] rdata_a_o,
  output logic [DATA_WIDTH-1:0] rdata_b_o,
  input  logic                  issue_i,
  input  logic [ADDR_WIDTH-1:0] issue_dest_i,
  output logic                  busy_a_o,
  output logic                  busy_b_o,
  output logic                  sb_full_o
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;
  localparam bit BYP_EN   = (BYPASS != 0);

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic                  wr_en;

  assign wr_en = we_i && (dest_reg_i != '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regs_q[r] <= '0;
      end
    end else if (wr_en) begin
      regs_q[dest_reg_i] <= wdata_i;
    end
  end

  // x0 is forced to zero at the port rather than relying on regs_q[0]
  always_comb begin
    rdata_a_o = regs_q[raddr_a_i];
    rdata_b_o = regs_q[raddr_b_i];
    if (BYP_EN && wr_en && dest_reg_i == raddr_a_i) rdata_a_o = wdata_i;
    if (BYP_EN && wr_en && dest_reg_i == raddr_b_i) rdata_b_o = wdata_i;
    if (raddr_a_i == '0) rdata_a_o = '0;
    if (raddr_b_i == '0) rdata_b_o = '0;
  end

  reg_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .CNT_WIDTH  (CNT_WIDTH),
    .BYPASS     (BYPASS)
  ) u_scoreboard (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .issue_i      (issue_i),
    .issue_dest_i (issue_dest_i),
    .we_i         (we_i),
    .dest_reg_i   (dest_reg_i),
    .raddr_a_i    (raddr_a_i),
    .raddr_b_i    (raddr_b_i),
    .busy_a_o     (busy_a_o),
    .busy_b_o     (busy_b_o),
    .sb_full_o    (sb_full_o)
  );

endmodule

// File: tb/tb_reg_file_sb.sv
// tb/tb_reg_file_sb.sv - bench for reg_file_sb with bypassed and non-bypassed instances
module tb_reg_file_sb;

  logic        clk_i  = 1'b0;
  logic        rst_ni = 1'b1;
  logic        we     = 1'b0;
  logic [4:0]  dest   = '0;
  logic [31:0] wdata  = '0;
  logic [4:0]  ra     = '0;
  logic [4:0]  rb     = '0;
  logic        iss    = 1'b0;
  logic [4:0]  idest  = '0;

  logic [31:0] rd_a_byp, rd_b_byp, rd_a_nob, rd_b_nob;
  logic        busy_a_byp, busy_b_byp, full_byp;
  logic        busy_a_nob, busy_b_nob, full_nob;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] m_regs [32];
  int          m_cnt  [32];

  always #5 clk_i = ~clk_i;

  reg_file_sb #(.BYPASS(1)) dut_byp (
    .clk_i(clk_i), .rst_ni(rst_ni), .we_i(we), .dest_reg_i(dest), .wdata_i(wdata),
    .raddr_a_i(ra), .raddr_b_i(rb), .rdata_a_o(rd_a_byp), .rdata_b_o(rd_b_byp),
    .issue_i(iss), .issue_dest_i(idest), .busy_a_o(busy_a_byp), .busy_b_o(busy_b_byp),
    .sb_full_o(full_byp)
  );

  reg_file_sb #(.BYPASS(0)) dut_nob (
    .clk_i(clk_i), .rst_ni(rst_ni), .we_i(we), .dest_reg_i(dest), .wdata_i(wdata),
    .raddr_a_i(ra), .raddr_b_i(rb), .rdata_a_o(rd_a_nob), .rdata_b_o(rd_b_nob),
    .issue_i(iss), .issue_dest_i(idest), .busy_a_o(busy_a_nob), .busy_b_o(busy_b_nob),
    .sb_full_o(full_nob)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_rd(input bit byp, input logic [4:0] a);
    if (a == 0) return 32'h0;
    if (byp && we && dest == a) return wdata;
    return m_regs[a];
  endfunction

  function automatic logic [31:0] exp_busy(input bit byp, input logic [4:0] a);
    bit b;
    b = (a != 0) && (m_cnt[a] > 0);
    if (byp && we && dest == a && m_cnt[a] == 1) b = 0;
    return {31'b0, b};
  endfunction

  function automatic logic [31:0] exp_full();
    return {31'b0, (idest != 0) && (m_cnt[idest] == 3)};
  endfunction

  function automatic logic [31:0] b2w(input logic b);
    return {31'b0, b};
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = '0;
      m_cnt[i]  = 0;
    end
  endtask

  task automatic model_update();
    bool_upd: begin
      bit inc, dec;
      inc = iss && idest != 0;
      dec = we && dest != 0;
      if (inc && dec && idest == dest) begin
        inc = 0;
        dec = 0;
      end
      if (inc && m_cnt[idest] < 3) m_cnt[idest]++;
      if (dec && m_cnt[dest] > 0) m_cnt[dest]--;
    end
    if (we && dest != 0) m_regs[dest] = wdata;
  endtask

  task automatic check_model();
    check("rd_a_byp",   rd_a_byp,        exp_rd(1, ra));
    check("rd_b_byp",   rd_b_byp,        exp_rd(1, rb));
    check("rd_a_nob",   rd_a_nob,        exp_rd(0, ra));
    check("rd_b_nob",   rd_b_nob,        exp_rd(0, rb));
    check("busy_a_byp", b2w(busy_a_byp), exp_busy(1, ra));
    check("busy_b_byp", b2w(busy_b_byp), exp_busy(1, rb));
    check("busy_a_nob", b2w(busy_a_nob), exp_busy(0, ra));
    check("busy_b_nob", b2w(busy_b_nob), exp_busy(0, rb));
    check("full_byp",   b2w(full_byp),   exp_full());
    check("full_nob",   b2w(full_nob),   exp_full());
  endtask

  task automatic step(input logic s_we, input logic [4:0] s_dest, input logic [31:0] s_wdata,
                      input logic [4:0] s_ra, input logic [4:0] s_rb,
                      input logic s_iss, input logic [4:0] s_idest);
    @(negedge clk_i);
    we = s_we; dest = s_dest; wdata = s_wdata;
    ra = s_ra; rb = s_rb; iss = s_iss; idest = s_idest;
    #1;
    check_model();
    model_update();
  endtask

  task automatic do_reset(input logic [4:0] s_ra, input logic [4:0] s_rb);
    @(posedge clk_i);
    #2;
    we = 0; iss = 0; ra = s_ra; rb = s_rb; idest = s_ra;
    rst_ni = 1'b0;
    #1;
    check("rst_rd_a",   rd_a_byp | rd_a_nob, 32'h0);
    check("rst_rd_b",   rd_b_byp | rd_b_nob, 32'h0);
    check("rst_busy",   b2w(busy_a_byp | busy_b_byp | busy_a_nob | busy_b_nob), 32'h0);
    check("rst_full",   b2w(full_byp | full_nob), 32'h0);
    model_clear();
    @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  initial begin
    model_clear();
    do_reset(5'd5, 5'd7);

    // x5 write then read
    step(0, 0, 0, 5, 0, 1, 5);
    step(0, 0, 0, 5, 0, 0, 0);
    step(1, 5, 32'hDEADBEEF, 5, 0, 0, 0);
    check("x5_byp_fwd", rd_a_byp, 32'hDEADBEEF);
    check("x5_nob_old", rd_a_nob, 32'h0);
    step(0, 0, 0, 5, 0, 0, 0);
    check("x5_read", rd_a_byp, 32'hDEADBEEF);
    check("x5_read_nob", rd_a_nob, 32'hDEADBEEF);

    // x0 ignores writes
    step(1, 0, 32'h1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    check("x0_read", rd_a_byp, 32'h0);

    // same-cycle write/read on x7
    step(0, 0, 0, 0, 7, 1, 7);
    step(1, 7, 32'h1234, 0, 7, 0, 0);
    check("x7_byp", rd_b_byp, 32'h1234);
    check("x7_nob", rd_b_nob, 32'h0);

    // x3 busy until retire
    step(0, 0, 0, 3, 0, 1, 3);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 3, 0, 0, 0);
      check("x3_busy", b2w(busy_a_byp), 32'h1);
    end
    step(1, 3, 32'hAA, 3, 0, 0, 0);
    check("x3_retire_busy", b2w(busy_a_byp), 32'h0);
    check("x3_retire_data", rd_a_byp, 32'hAA);
    check("x3_nob_busy", b2w(busy_a_nob), 32'h1);

    // x4 saturation
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 4, 1, 4);
    step(0, 0, 0, 0, 4, 0, 4);
    check("x4_full", b2w(full_byp), 32'h1);
    step(1, 4, 32'h44, 0, 4, 1, 4);
    step(0, 0, 0, 0, 4, 0, 4);
    check("x4_still_full", b2w(full_nob), 32'h1);
    for (int i = 0; i < 3; i++) step(1, 4, 32'h40 + i, 0, 4, 0, 4);
    step(0, 0, 0, 0, 4, 0, 4);
    check("x4_drained_busy", b2w(busy_b_byp | busy_b_nob), 32'h0);
    check("x4_drained_full", b2w(full_byp), 32'h0);

    // own destination does not stall own source
    step(0, 0, 0, 9, 0, 1, 9);
    check("x9_same_cycle", b2w(busy_a_byp | busy_a_nob), 32'h0);
    step(0, 0, 0, 9, 0, 0, 0);
    check("x9_next_cycle", b2w(busy_a_byp), 32'h1);

    // randomized legal traffic with one mid-stream reset
    for (int n = 0; n < 3000; n++) begin
      logic        r_we, r_iss;
      logic [4:0]  r_dest, r_idest;
      if (n == 1500) do_reset(5'($urandom_range(0, 11)), 5'($urandom_range(0, 11)));
      r_dest = 5'($urandom_range(0, 11));
      r_we   = ($urandom_range(0, 1) == 1) && (r_dest == 0 || m_cnt[r_dest] > 0);
      r_idest = 5'($urandom_range(0, 11));
      r_iss  = ($urandom_range(0, 1) == 1) &&
               (m_cnt[r_idest] < 3 || (r_we && r_dest == r_idest));
      step(r_we, r_dest, $urandom, 5'($urandom_range(0, 11)), 5'($urandom_range(0, 11)),
           r_iss, r_idest);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
